fir_interp2: RTL and testbench

- 2x polyphase interpolating FIR on the playback path: accepts 16-bit Q15 PCM at the base rate and emits two filtered Q15 samples per input toward the DAC/I2S transmitter.
- Counterpart of the 32-tap decimation compensation filter on the capture path. Uses the same 32-tap symmetric Q15 prototype, split into even and odd 16-tap phases.
- Time-multiplexed: two MACs (one per phase), 16 cycles per input sample, with a valid/ready handshake on both sides.

---
 rtl/fir_interp2.sv | 212 +++++++++++++++++++++
 tb/tb_fir_interp2.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_interp2.sv
// fir_interp2: 2x polyphase interpolating FIR for the playback path.
// Each accepted Q15 sample yields two filtered Q15 outputs: the even-phase
// sample (h[2k]) followed by the odd-phase sample (h[2k+1]), k = 0..15.
// Two MACs run in parallel for 16 cycles per input sample.
//
// Build option: define FIR_INTERP2_ROUND_EN to round half up before the
// output shift; otherwise the shift truncates (floor).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. x_in_ready is only 1 in IDLE. y_out, y_out_phase and
// y_out_valid hold stable while y_out_valid=1 and y_out_ready=0.
//
// state_dbg exposes the FSM state (IDLE=0, MAC=1, ROUND=2, SEND_E=3,
// SEND_O=4) for checkers.
module fir_interp2 #(
  parameter int ACC_W     = 38,
  parameter int OUT_SHIFT = 14
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] x_in,
  input  logic        x_in_valid,
  output logic        x_in_ready,
  output logic [15:0] y_out,
  output logic        y_out_valid,
  input  logic        y_out_ready,
  output logic        y_out_phase,
  output logic        sat_pulse,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MAC    = 3'd1,
    ROUND  = 3'd2,
    SEND_E = 3'd3,
    SEND_O = 3'd4
  } state_t;

  localparam logic signed [ACC_W-1:0] MAX_Q15 = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_Q15 = -(ACC_W'(32768));
`ifdef FIR_INTERP2_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (OUT_SHIFT - 1);
`endif

  state_t state;
  state_t state_nxt;

  logic signed [15:0]      hist [16];
  logic signed [ACC_W-1:0] acc_e;
  logic signed [ACC_W-1:0] acc_o;
  logic [3:0]              k;
  logic [15:0]             odd_hold;

  // FSM strobes
  logic accept;
  logic mac_en;
  logic round_en;
  logic send_e_done;
  logic send_o_done;

  // datapath intermediates
  logic signed [15:0]      coef_e;
  logic signed [15:0]      coef_o;
  logic signed [31:0]      prod_e;
  logic signed [31:0]      prod_o;
  logic signed [ACC_W-1:0] prod_e_ext;
  logic signed [ACC_W-1:0] prod_o_ext;
  logic signed [ACC_W-1:0] acc_e_r;
  logic signed [ACC_W-1:0] acc_o_r;
  logic signed [ACC_W-1:0] sh_e;
  logic signed [ACC_W-1:0] sh_o;
  logic [15:0]             res_e;
  logic [15:0]             res_o;
  logic                    clip_e;
  logic                    clip_o;

  // First half of the symmetric 32-tap prototype; the upper half mirrors it,
  // so for idx >= 16 the table index is 31-idx, i.e. the inverted low nibble.
  function automatic logic signed [15:0] coef(input logic [4:0] idx);
    logic [3:0] m;
    m = idx[4] ? ~idx[3:0] : idx[3:0];
    coef = 16'sd0;
    case (m)
      4'd0:  coef = 16'sd1;
      4'd1:  coef = 16'sd24;
      4'd2:  coef = 16'sd75;
      4'd3:  coef = 16'sd91;
      4'd4:  coef = -16'sd28;
      4'd5:  coef = -16'sd249;
      4'd6:  coef = -16'sd300;
      4'd7:  coef = 16'sd91;
      4'd8:  coef = 16'sd700;
      4'd9:  coef = 16'sd732;
      4'd10: coef = -16'sd361;
      4'd11: coef = -16'sd1817;
      4'd12: coef = -16'sd1666;
      4'd13: coef = 16'sd1525;
      4'd14: coef = 16'sd6769;
      4'd15: coef = 16'sd10843;
      default: coef = 16'sd0;
    endcase
  endfunction

  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (x_in_valid && x_in_ready) state_nxt = MAC;
      MAC:     if (k == 4'd15)               state_nxt = ROUND;
      ROUND:                                 state_nxt = SEND_E;
      SEND_E:  if (y_out_ready)              state_nxt = SEND_O;
      SEND_O:  if (y_out_ready)              state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Output/strobe decode for the datapath
  always_comb begin
    accept      = (state == IDLE) && x_in_valid && x_in_ready;
    mac_en      = (state == MAC);
    round_en    = (state == ROUND);
    send_e_done = (state == SEND_E) && y_out_ready;
    send_o_done = (state == SEND_O) && y_out_ready;
  end

  // Per-tap products for both phases, sign-extended to accumulator width
  always_comb begin
    coef_e     = coef({k, 1'b0});
    coef_o     = coef({k, 1'b1});
    prod_e     = hist[k] * coef_e;
    prod_o     = hist[k] * coef_o;
    prod_e_ext = {{(ACC_W-32){prod_e[31]}}, prod_e};
    prod_o_ext = {{(ACC_W-32){prod_o[31]}}, prod_o};
  end

  // Scale accumulators to Q15 and clip to the 16-bit range
  always_comb begin
`ifdef FIR_INTERP2_ROUND_EN
    acc_e_r = acc_e + RND_HALF;
    acc_o_r = acc_o + RND_HALF;
`else
    acc_e_r = acc_e;
    acc_o_r = acc_o;
`endif
    sh_e   = acc_e_r >>> OUT_SHIFT;
    sh_o   = acc_o_r >>> OUT_SHIFT;
    clip_e = (sh_e > MAX_Q15) || (sh_e < MIN_Q15);
    clip_o = (sh_o > MAX_Q15) || (sh_o < MIN_Q15);
    if (sh_e > MAX_Q15)      res_e = 16'h7fff;
    else if (sh_e < MIN_Q15) res_e = 16'h8000;
    else                     res_e = sh_e[15:0];
    if (sh_o > MAX_Q15)      res_o = 16'h7fff;
    else if (sh_o < MIN_Q15) res_o = 16'h8000;
    else                     res_o = sh_o[15:0];
  end

  // History, accumulators, tap counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) hist[i] <= 16'sd0;
      acc_e       <= '0;
      acc_o       <= '0;
      k           <= 4'd0;
      odd_hold    <= 16'd0;
      x_in_ready  <= 1'b0;
      y_out       <= 16'd0;
      y_out_valid <= 1'b0;
      y_out_phase <= 1'b0;
      sat_pulse   <= 1'b0;
    end else begin
      x_in_ready <= (state_nxt == IDLE);
      sat_pulse  <= 1'b0;
      if (accept) begin
        hist[0] <= x_in;
        for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
        acc_e <= '0;
        acc_o <= '0;
        k     <= 4'd0;
      end
      if (mac_en) begin
        acc_e <= acc_e + prod_e_ext;
        acc_o <= acc_o + prod_o_ext;
        k     <= k + 4'd1;
      end
      if (round_en) begin
        odd_hold    <= res_o;
        y_out       <= res_e;
        y_out_valid <= 1'b1;
        y_out_phase <= 1'b0;
        sat_pulse   <= clip_e | clip_o;
      end
      if (send_e_done) begin
        y_out       <= odd_hold;
        y_out_phase <= 1'b1;
      end
      if (send_o_done) begin
        y_out_valid <= 1'b0;
        y_out_phase <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_interp2.sv
// tb_fir_interp2: randomized and directed bench for fir_interp2. Expected
// outputs come from a direct convolution of the input history with the
// 32-tap prototype split into even/odd phases.
module tb_fir_interp2;

  logic        clk;
  logic        reset_n;
  logic [15:0] x_in;
  logic        x_in_valid;
  logic        x_in_ready;
  logic [15:0] y_out;
  logic        y_out_valid;
  logic        y_out_ready;
  logic        y_out_phase;
  logic        sat_pulse;
  logic [2:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // scoreboard
  logic [15:0] exp_q[$];
  logic        ph_q[$];
  logic        sat_q[$];
  int          mh[16];
  int          h_tab[32] = '{1, 24, 75, 91, -28, -249, -300, 91,
                             700, 732, -361, -1817, -1666, 1525, 6769, 10843,
                             10843, 6769, 1525, -1666, -1817, -361, 732, 700,
                             91, -300, -249, -28, 91, 75, 24, 1};

  fir_interp2 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x_in        (x_in),
    .x_in_valid  (x_in_valid),
    .x_in_ready  (x_in_ready),
    .y_out       (y_out),
    .y_out_valid (y_out_valid),
    .y_out_ready (y_out_ready),
    .y_out_phase (y_out_phase),
    .sat_pulse   (sat_pulse),
    .state_dbg   (state_dbg)
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // reference model: convolve history with each phase, scale, clip
  task automatic model_push(input logic signed [15:0] x);
    longint se, so, re, ro;
    for (int i = 15; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = int'(x);
    se = 0;
    so = 0;
    for (int j = 0; j < 16; j++) begin
      se += longint'(mh[j]) * longint'(h_tab[2*j]);
      so += longint'(mh[j]) * longint'(h_tab[2*j+1]);
    end
`ifdef FIR_INTERP2_ROUND_EN
    se += 8192;
    so += 8192;
`endif
    re = se >>> 14;
    ro = so >>> 14;
    sat_q.push_back((re > 32767) || (re < -32768) || (ro > 32767) || (ro < -32768));
    if (re > 32767) re = 32767;
    if (re < -32768) re = -32768;
    if (ro > 32767) ro = 32767;
    if (ro < -32768) ro = -32768;
    exp_q.push_back(re[15:0]);
    ph_q.push_back(1'b0);
    exp_q.push_back(ro[15:0]);
    ph_q.push_back(1'b1);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mh[i] = 0;
    exp_q.delete();
    ph_q.delete();
    sat_q.delete();
  endtask

  // driver: reset pulse, released on a negative edge
  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    reset_n = 1'b1;
  endtask

  // driver: one input sample through to its two outputs; entered on a
  // negative edge, returns on the negative edge after the last transfer.
  // bp = cycles of y_out_ready=0 applied to the even sample.
  task automatic do_sample(input logic signed [15:0] x, input int bp,
                           input bit stream, output int acc_cyc);
    int n, got, hold, lat;
    logic [15:0] held_y, e;
    logic ep, es;
    x_in = x;
    x_in_valid = 1'b1;
    n = 0;
    while (x_in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (x_in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: x_in_ready=%b required 1", x_in_ready);
      x_in_valid = 1'b0;
      acc_cyc = cycle;
      return;
    end
    @(negedge clk);
    acc_cyc = cycle;
    if (!stream) x_in_valid = 1'b0;
    model_push(x);
    got = 0;
    hold = 0;
    lat = -1;
    n = 0;
    held_y = exp_q[0];
    while (got < 2 && n < 200) begin
      if (y_out_valid === 1'b1) begin
        if (lat < 0) begin
          // edges counted with the accept edge as the first one
          lat = cycle - acc_cyc + 1;
          es = sat_q.pop_front();
          n_tests++;
          if (lat != 18) begin
            n_fail++;
            $display("FAIL latency: got %0d edges required 18", lat);
          end
          n_tests++;
          if (sat_pulse !== es) begin
            n_fail++;
            $display("FAIL sat_pulse: got %b required %b (x=%0d)", sat_pulse, es, x);
          end
        end
        if (got == 0 && hold < bp) begin
          y_out_ready = 1'b0;
          hold++;
          n_tests++;
          if (y_out !== held_y || y_out_phase !== 1'b0 || x_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable: y=%h ph=%b rdy=%b required y=%h ph=0 rdy=0",
                     y_out, y_out_phase, x_in_ready, held_y);
          end
        end else begin
          y_out_ready = 1'b1;
          e = exp_q.pop_front();
          ep = ph_q.pop_front();
          n_tests++;
          if (y_out !== e || y_out_phase !== ep) begin
            n_fail++;
            $display("FAIL y_out: got %0d ph %b required %0d ph %b (x=%0d)",
                     $signed(y_out), y_out_phase, $signed(e), ep, x);
          end
          got++;
        end
      end
      @(negedge clk);
      n++;
    end
    if (got < 2) begin
      n_tests++;
      n_fail++;
      $display("FAIL output_timeout: got %0d outputs required 2", got);
    end
  endtask

  task automatic test_reset();
    int ac;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (x_in_ready !== 1'b0 || y_out !== 16'd0 || y_out_valid !== 1'b0 ||
        y_out_phase !== 1'b0 || sat_pulse !== 1'b0 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b y=%h v=%b ph=%b sat=%b st=%0d required all 0",
               x_in_ready, y_out, y_out_valid, y_out_phase, sat_pulse, state_dbg);
    end
    apply_reset();
    n_tests++;
    if (x_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b required 0", x_in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (x_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b required 1", x_in_ready);
    end
    ac = 0;
  endtask

  task automatic test_impulse();
    int ac;
    do_sample(16'sd16384, 0, 1'b0, ac);
    for (int i = 0; i < 15; i++) do_sample(16'sd0, 0, 1'b0, ac);
  endtask

  task automatic test_dc_sat(input logic signed [15:0] v);
    int ac;
    for (int i = 0; i < 20; i++) do_sample(v, 0, 1'b0, ac);
  endtask

  task automatic test_backpressure();
    int ac;
    do_sample(16'(($urandom_range(0, 65535))), 10, 1'b0, ac);
    n_tests++;
    if (x_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_odd: got %b required 1", x_in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int ac, prev;
    do_sample(16'(($urandom_range(0, 65535))), 0, 1'b1, prev);
    for (int i = 0; i < 4; i++) begin
      do_sample(16'(($urandom_range(0, 65535))), 0, 1'b1, ac);
      n_tests++;
      if (ac - prev != 20) begin
        n_fail++;
        $display("FAIL accept_spacing: got %0d cycles required 20", ac - prev);
      end
      prev = ac;
    end
    x_in_valid = 1'b0;
  endtask

  task automatic test_random();
    int ac;
    for (int i = 0; i < 12; i++)
      do_sample(16'(($urandom_range(0, 65535))), $urandom_range(0, 3), 1'b0, ac);
  endtask

  task automatic test_reset_mid_mac();
    int n;
    x_in = 16'sd1234;
    x_in_valid = 1'b1;
    n = 0;
    while (x_in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    x_in_valid = 1'b0;
    repeat (7) @(negedge clk);
    n_tests++;
    if (state_dbg !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_mac_state: got %0d required 1", state_dbg);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (x_in_ready !== 1'b0 || y_out !== 16'd0 || y_out_valid !== 1'b0 ||
        y_out_phase !== 1'b0 || sat_pulse !== 1'b0 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_mac_reset: rdy=%b y=%h v=%b ph=%b sat=%b st=%0d required all 0",
               x_in_ready, y_out, y_out_valid, y_out_phase, sat_pulse, state_dbg);
    end
    @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    @(negedge clk);
    test_impulse();
  endtask

  initial begin
    reset_n     = 1'b0;
    x_in        = 16'd0;
    x_in_valid  = 1'b0;
    y_out_ready = 1'b1;
    model_clear();
    @(negedge clk);
    test_reset();
    test_impulse();
    test_dc_sat(16'sh7fff);
    test_dc_sat(16'sh8000);
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
